// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART block family (uart_rx, uart_tx and the
// uart_tx_arbiter that shares one transmitter between several requesters).
//
// Contents:
//   CLK_FREQ / BAUD_RATE : system clock and line rate shared with uart_rx/uart_tx
//   BYTE_W               : data byte width
//   arb_state_t          : uart_tx_arbiter FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 9600;
    localparam int BYTE_W    = 8;

    // ST_GRANT:     owner holds the TX, waiting for a byte and an idle uart_tx
    // ST_WAIT_BUSY: strobe issued, waiting for uart_tx to report busy
    // ST_WAIT_DONE: frame in flight, waiting for busy to fall
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector: returns the first set request at
// or after ptr, scanning cyclically.
//
// Ports:
//   req   [N_REQ-1:0] request vector
//   ptr   [PW-1:0]    highest-priority index (0..N_REQ-1)
//   grant [N_REQ-1:0] one-hot winner, zero when no request is set
//   idx   [PW-1:0]    index of the winner (0 when no request is set)
//   found             at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             found
);

    logic          found_hi;
    logic [PW-1:0] idx_hi;
    logic [PW-1:0] idx_any;

    // Two candidates: the lowest request at or above ptr, and the lowest
    // request overall. The first wins if it exists, otherwise the scan has
    // wrapped and the lowest request overall is next in cyclic order.
    always_comb begin
        found_hi = 1'b0;
        idx_hi   = '0;
        found    = 1'b0;
        idx_any  = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                found   = 1'b1;
                idx_any = PW'(j);
                if (j >= int'(ptr)) begin
                    found_hi = 1'b1;
                    idx_hi   = PW'(j);
                end
            end
        end
        idx   = found_hi ? idx_hi : idx_any;
        grant = found ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between N_REQ packet-level requesters. A requester owns
// the transmitter for a whole packet (up to and including the byte flagged
// last); ownership rotates round-robin between packets.
//
// Handshake (requester side): the owner holds i_req high for the packet and
// presents i_valid/i_data/i_last; o_ready[k] pulses for exactly one cycle when
// the byte was taken, after which the requester moves to its next byte.
// Bytes from non-owners are ignored; there is no preemption.
//
// Ports:
//   i_clk_sys, i_rst_n  clock, synchronous active-low reset
//   i_req/i_valid/i_last/i_data  per-requester packet interface
//   o_ready   one-cycle byte-accepted pulse per requester
//   o_grant   one-hot current owner, zero when idle
//   o_scd_flag/o_scd_data  one-cycle send strobe and held byte to uart_tx
//   i_tx_busy uart_tx frame in progress
//   o_abort   watchdog revoked the grant (zero unless the watchdog is built)
//   o_dbg_state  current FSM state
//
// Build option: define UART_TX_ARB_TIMEOUT_EN to add a stall watchdog that
// revokes the grant after TIMEOUT_CYC cycles in GRANT without a valid byte.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                      i_clk_sys,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_valid,
    input  logic [N_REQ-1:0]          i_last,
    input  logic [BYTE_W*N_REQ-1:0]   i_data,
    output logic [N_REQ-1:0]          o_ready,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_scd_flag,
    output logic [BYTE_W-1:0]         o_scd_data,
    input  logic                      i_tx_busy,
    output logic [N_REQ-1:0]          o_abort,
    output arb_state_t                o_dbg_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("uart_tx_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
    end

    arb_state_t        state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic              last_q;

    logic [N_REQ-1:0]  pick_grant;
    logic [PW-1:0]     pick_idx;
    logic              pick_found;

    logic [BYTE_W-1:0] data_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign data_arr[k] = i_data[k*BYTE_W +: BYTE_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req   (i_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Next-priority pointer after owner g; wraps explicitly because N_REQ
    // need not be a power of two.
    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
        if (g == PW'(N_REQ - 1)) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    assign o_dbg_state = state;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] idle_cnt;
`else
    assign o_abort = '0;
`endif

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            last_q     <= 1'b0;
            o_grant    <= '0;
            o_ready    <= '0;
            o_scd_flag <= 1'b0;
            o_scd_data <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            o_abort    <= '0;
            idle_cnt   <= '0;
`endif
        end else begin
            o_ready    <= '0;
            o_scd_flag <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            o_abort    <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        o_grant <= pick_grant;
                        owner   <= pick_idx;
                        state   <= ST_GRANT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end

                ST_GRANT: begin
                    if (!i_req[owner]) begin
                        // Abandoned packet: treated like a completed one.
                        o_grant <= '0;
                        rr_ptr  <= ptr_after(owner);
                        state   <= ST_IDLE;
                    end else if (i_valid[owner] && !i_tx_busy) begin
                        o_scd_flag <= 1'b1;
                        o_scd_data <= data_arr[owner];
                        o_ready    <= o_grant;
                        last_q     <= i_last[owner];
                        state      <= ST_WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        idle_cnt   <= '0;
                    end else if (!i_valid[owner]) begin
                        if (idle_cnt == CW'(TIMEOUT_CYC - 1)) begin
                            o_abort  <= o_grant;
                            o_grant  <= '0;
                            rr_ptr   <= ptr_after(owner);
                            state    <= ST_IDLE;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
`endif
                    end
                end

                // uart_tx may take one or more cycles to raise busy after the
                // strobe; waiting for it here keeps the next byte from being
                // judged against a stale idle busy.
                ST_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (last_q) begin
                            o_grant <= '0;
                            rr_ptr  <= ptr_after(owner);
                            state   <= ST_IDLE;
                        end else begin
                            state <= ST_GRANT;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with N_REQ=3. A behavioural uart_tx
// (busy rises the cycle after the strobe and lasts 20 cycles) and per-requester
// byte FIFOs drive the DUT; expected uart byte order comes from a packet-level
// round-robin model over the queued packets.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N     = 3;
    localparam int FRAME = 20;
    localparam int DEPTH = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   req, valid, last;
    logic [8*N-1:0] data;
    logic           busy;
    logic [N-1:0]   o_ready, o_grant, o_abort;
    logic           o_scd_flag;
    logic [7:0]     o_scd_data;
    arb_state_t     dbg_state;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (100)
    ) dut (
        .i_clk_sys   (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_valid     (valid),
        .i_last      (last),
        .i_data      (data),
        .o_ready     (o_ready),
        .o_grant     (o_grant),
        .o_scd_flag  (o_scd_flag),
        .o_scd_data  (o_scd_data),
        .i_tx_busy   (busy),
        .o_abort     (o_abort),
        .o_dbg_state (dbg_state)
    );

    // ---------------- bench state ----------------
    logic [8:0]  src_mem [N][DEPTH];  // bit 8 = last
    int          head [N];
    int          tail [N];
    bit          stall [N];
    bit          drop [N];
    bit          force_busy;
    int          busy_left;
    bit          start_pending;

    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    logic [N-1:0] abort_log [$];

    int          cyc;
    int          last_strobe_cyc;
    int          spacing_err, ready_err, hold_err;
    int          ready_cnt [N];
    logic [7:0]  last_data;
    int          model_ptr;
    int          n_tests, n_fail;

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            bit pend;
            pend = head[k] < tail[k];
            req[k]        = pend && !drop[k];
            valid[k]      = pend && !drop[k] && !stall[k];
            data[8*k +: 8] = pend ? src_mem[k][head[k]][7:0] : 8'h00;
            last[k]       = pend && src_mem[k][head[k]][8];
        end
        busy = (busy_left > 0) || force_busy;
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input bit is_last);
        if (head[k] == tail[k]) begin
            head[k] = 0;
            tail[k] = 0;
        end
        src_mem[k][tail[k]] = {is_last, b};
        tail[k]++;
    endtask

    // One clock: sample outputs at the falling edge, log them, advance the
    // uart_tx model and the requesters, then drive the next inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            last_data       = 8'h00;
            last_strobe_cyc = -1;
        end else if (o_scd_flag) begin
            got_q.push_back(o_scd_data);
            if (last_strobe_cyc >= 0 && cyc - last_strobe_cyc < FRAME + 2) spacing_err++;
            last_strobe_cyc = cyc;
            last_data       = o_scd_data;
            if ($countones(o_ready) != 1) ready_err++;
        end else begin
            if (o_ready != '0) ready_err++;
            if (o_scd_data !== last_data) hold_err++;
        end
        for (int k = 0; k < N; k++) begin
            if (o_ready[k]) begin
                ready_cnt[k]++;
                if (head[k] < tail[k]) head[k]++;
            end
        end
        if (o_abort != '0) abort_log.push_back(o_abort);
        if (busy_left > 0) busy_left--;
        if (start_pending) begin
            busy_left     = FRAME;
            start_pending = 1'b0;
        end
        if (o_scd_flag && rst_n) start_pending = 1'b1;
        drive_inputs();
    endtask

    task automatic run_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (head[0] == tail[0] && head[1] == tail[1] && head[2] == tail[2] &&
                o_grant == '0 && busy_left == 0 && !start_pending && dbg_state == ST_IDLE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        abort_log.delete();
        for (int k = 0; k < N; k++) ready_cnt[k] = 0;
    endtask

    // ---------------- reference model ----------------
    // Packet-level round robin: from the pointer, the next requester with a
    // queued packet sends its whole packet; the pointer then moves past it.
    task automatic build_expect();
        int h [N];
        int p;
        exp_q.delete();
        h = head;
        p = model_ptr;
        forever begin
            int  k;
            bit  lf;
            k = -1;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (p + i) % N;
                if (k < 0 && h[c] < tail[c]) k = c;
            end
            if (k < 0) break;
            lf = 1'b0;
            while (!lf && h[k] < tail[k]) begin
                exp_q.push_back(src_mem[k][h[k]][7:0]);
                lf = src_mem[k][h[k]][8];
                h[k]++;
            end
            p = (k + 1) % N;
        end
        model_ptr = p;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_inputs();
        step();
        step();
        n_tests++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant got %b exp 000", o_grant); end
        n_tests++; if (o_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b exp 000", o_ready); end
        n_tests++; if (o_scd_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag got %b exp 0", o_scd_flag); end
        n_tests++; if (o_scd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", o_scd_data); end
        n_tests++; if (o_abort !== 3'b000) begin n_fail++; $display("FAIL reset_abort got %b exp 000", o_abort); end
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
        rst_n     = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_single_packet();
        bit ok;
        clear_logs();
        push_byte(0, 8'h5A, 1'b0);
        push_byte(0, 8'h6A, 1'b1);
        build_expect();
        drive_inputs();
        run_drain(200, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_drain got timeout exp idle"); end
        n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL single_count got %0d exp 2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (ready_cnt[0] != 2) begin n_fail++; $display("FAIL single_ready got %0d exp 2", ready_cnt[0]); end
        n_tests++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL single_grant_end got %b exp 000", o_grant); end
    endtask

    task automatic test_contention();
        bit ok;
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        model_ptr = 0;
        clear_logs();
        push_byte(0, 8'h11, 1'b1);
        push_byte(1, 8'h22, 1'b1);
        push_byte(2, 8'h33, 1'b1);
        build_expect();
        drive_inputs();
        run_drain(300, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL contention_drain got timeout exp idle"); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL contention_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL contention_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        clear_logs();
        push_byte(0, 8'h11, 1'b1);
        push_byte(1, 8'h22, 1'b1);
        build_expect();
        // r0 keeps requesting with back-to-back packets; r1 must interleave
        push_byte(0, 8'h40, 1'b0);
        push_byte(0, 8'h41, 1'b1);
        push_byte(0, 8'h42, 1'b1);
        push_byte(0, 8'h43, 1'b1);
        push_byte(1, 8'h50, 1'b1);
        push_byte(1, 8'h51, 1'b1);
        model_ptr = 0;
        build_expect();
        drive_inputs();
        run_drain(600, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL fairness_drain got timeout exp idle"); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fairness_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fairness_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_busy_holdoff();
        bit ok;
        int n0, strobes, readies;
        clear_logs();
        force_busy = 1'b1;
        push_byte(2, 8'h77, 1'b1);
        build_expect();
        drive_inputs();
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = (o_grant == 3'b100);
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL holdoff_grant got %b exp 100", o_grant); end
        n0 = got_q.size();
        for (int i = 0; i < 50; i++) step();
        strobes = got_q.size() - n0;
        readies = ready_cnt[2];
        n_tests++; if (strobes != 0) begin n_fail++; $display("FAIL holdoff_strobe got %0d exp 0", strobes); end
        n_tests++; if (readies != 0) begin n_fail++; $display("FAIL holdoff_ready got %0d exp 0", readies); end
        force_busy = 1'b0;
        drive_inputs();
        step();
        n_tests++; if (got_q.size() != n0 + 1) begin n_fail++; $display("FAIL holdoff_release got %0d strobes exp 1", got_q.size() - n0); end
        n_tests++; if (o_scd_data !== exp_q[0]) begin n_fail++; $display("FAIL holdoff_data got %h exp %h", o_scd_data, exp_q[0]); end
        n_tests++; if (o_ready !== 3'b100) begin n_fail++; $display("FAIL holdoff_ready_pulse got %b exp 100", o_ready); end
        run_drain(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL holdoff_drain got timeout exp idle"); end
    endtask

    task automatic test_abandon();
        bit ok;
        int n0;
        clear_logs();
        force_busy = 1'b1;
        push_byte(1, 8'h99, 1'b1);
        drive_inputs();
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = (o_grant == 3'b010);
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abandon_grant got %b exp 010", o_grant); end
        drop[1] = 1'b1;
        drive_inputs();
        n0 = got_q.size();
        step();
        n_tests++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL abandon_drop got %b exp 000", o_grant); end
        n_tests++; if (got_q.size() != n0 || ready_cnt[1] != 0) begin n_fail++; $display("FAIL abandon_strobe got %0d strobes exp 0", got_q.size() - n0); end
        head[1]    = tail[1];
        drop[1]    = 1'b0;
        force_busy = 1'b0;
        model_ptr  = 2;
        drive_inputs();
        step();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        clear_logs();
        push_byte(0, 8'hA1, 1'b0);
        push_byte(0, 8'hA2, 1'b1);
        drive_inputs();
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = (dbg_state == ST_WAIT_DONE);
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL midreset_reach got %0d exp %0d", dbg_state, ST_WAIT_DONE); end
        rst_n   = 1'b0;
        head[0] = tail[0];
        drive_inputs();
        step();
        n_tests++; if (o_grant !== 3'b000 || o_ready !== 3'b000 || o_abort !== 3'b000) begin n_fail++; $display("FAIL midreset_vec got grant %b ready %b abort %b exp 000", o_grant, o_ready, o_abort); end
        n_tests++; if (o_scd_flag !== 1'b0 || o_scd_data !== 8'h00) begin n_fail++; $display("FAIL midreset_scd got %b/%h exp 0/00", o_scd_flag, o_scd_data); end
        n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midreset_state got %0d exp %0d", dbg_state, ST_IDLE); end
        rst_n     = 1'b1;
        model_ptr = 0;
        run_drain(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL midreset_drain got timeout exp idle"); end
    endtask

    task automatic test_stall();
        bit ok;
        clear_logs();
        stall[2] = 1'b1;
        push_byte(2, 8'hC3, 1'b1);
        drive_inputs();
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = (o_grant == 3'b100);
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_grant got %b exp 100", o_grant); end
`ifdef UART_TX_ARB_TIMEOUT_EN
        push_byte(0, 8'hC0, 1'b1);
        drive_inputs();
        for (int i = 0; i < 150 && abort_log.size() == 0; i++) step();
        n_tests++; if (abort_log.size() != 1) begin n_fail++; $display("FAIL stall_abort_count got %0d exp 1", abort_log.size()); end
        n_tests++; if (abort_log.size() > 0 && abort_log[0] !== 3'b100) begin n_fail++; $display("FAIL stall_abort_vec got %b exp 100", abort_log[0]); end
        model_ptr = 0;
        stall[2]  = 1'b0;
        build_expect();
        drive_inputs();
        run_drain(200, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_drain got timeout exp idle"); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
`else
        for (int i = 0; i < 300; i++) step();
        n_tests++; if (o_grant !== 3'b100) begin n_fail++; $display("FAIL stall_hold got %b exp 100", o_grant); end
        n_tests++; if (abort_log.size() != 0) begin n_fail++; $display("FAIL stall_abort got %0d pulses exp 0", abort_log.size()); end
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL stall_strobe got %0d exp 0", got_q.size()); end
        stall[2]  = 1'b0;
        model_ptr = 2;
        build_expect();
        drive_inputs();
        run_drain(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_drain got timeout exp idle"); end
        n_tests++; if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin n_fail++; $display("FAIL stall_byte got %0d bytes exp C3", got_q.size()); end
`endif
    endtask

    task automatic test_random();
        bit ok;
        int total, rsum;
        for (int r = 0; r < 8; r++) begin
            clear_logs();
            total = 0;
            for (int k = 0; k < N; k++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        push_byte(k, 8'($urandom_range(0, 255)), b == len - 1);
                        total++;
                    end
                end
            end
            build_expect();
            drive_inputs();
            run_drain(30 * total + 50, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL random%0d_drain got timeout exp idle", r); end
            n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random%0d_count got %0d exp %0d", r, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random%0d_byte%0d got %h exp %h", r, i, got_q[i], exp_q[i]); end
            end
            rsum = ready_cnt[0] + ready_cnt[1] + ready_cnt[2];
            n_tests++; if (rsum != total) begin n_fail++; $display("FAIL random%0d_ready got %0d exp %0d", r, rsum, total); end
        end
    endtask

    task automatic test_invariants();
        n_tests++; if (spacing_err != 0) begin n_fail++; $display("FAIL strobe_spacing got %0d violations exp 0", spacing_err); end
        n_tests++; if (ready_err != 0) begin n_fail++; $display("FAIL ready_per_frame got %0d violations exp 0", ready_err); end
        n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL data_hold got %0d violations exp 0", hold_err); end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        n_tests = 0; n_fail = 0;
        cyc = 0; last_strobe_cyc = -1;
        spacing_err = 0; ready_err = 0; hold_err = 0;
        force_busy = 1'b0; busy_left = 0; start_pending = 1'b0;
        last_data = 8'h00; model_ptr = 0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0; tail[k] = 0; stall[k] = 1'b0; drop[k] = 1'b0; ready_cnt[k] = 0;
        end
        req = '0; valid = '0; last = '0; data = '0; busy = 1'b0;

        test_reset();
        test_single_packet();
        test_contention();
        test_fairness();
        test_busy_holdoff();
        test_abandon();
        test_reset_mid_frame();
        test_stall();
        test_random();
        test_invariants();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N_REQ packet-level requesters (command ACK, status reporter, debug echo).
- Grants the TX to one requester for a whole packet (bytes up to and including the one marked last), with round-robin fairness between packets.
- Sequences the transmitter through its one-cycle send-flag/data strobe and waits on its busy signal.
- Sits in top between the frame controller logic and uart_tx.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYC, 1_000_000, idle-cycle limit for the optional stall watchdog (20 ms at 50 MHz).

Ports:
- i_clk_sys  in  1  system clock, 50 MHz.
- i_rst_n  in  1  synchronous active-low reset.
- i_req  in  N_REQ  per-requester packet request; level, held high for the whole packet.
- i_valid  in  N_REQ  per-requester byte available.
- i_last  in  N_REQ  qualifies i_valid; this byte ends the packet.
- i_data  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- o_ready  out  N_REQ  one-cycle pulse: the byte of requester k was accepted.
- o_grant  out  N_REQ  one-hot current owner; all zero when idle.
- o_scd_flag  out  1  one-cycle send strobe to uart_tx.
- o_scd_data  out  8  byte to uart_tx; valid with o_scd_flag and held until the next strobe.
- i_tx_busy  in  1  uart_tx frame in progress.
- o_abort  out  N_REQ  one-cycle pulse: grant revoked by the watchdog (feature only; tied 0 otherwise).

Behaviour:
- Reset: clock/reset are i_clk_sys / i_rst_n; reset is synchronous, active-low. On reset all outputs are 0, FSM goes to IDLE and the rr pointer goes to 0. Reset mid-frame drops the grant immediately; the frame already in uart_tx is not recalled.
- IDLE:
  - If any i_req is high, select the first requester at or after rr_ptr (cyclic order).
  - Register o_grant one-hot and go to GRANT. One cycle of latency from i_req to o_grant.
- GRANT (owner g):
  - If i_req[g]=0: clear o_grant and go to IDLE. rr_ptr is updated as for a completed packet.
  - Else if i_valid[g]=1 and i_tx_busy=0: in the same cycle pulse o_scd_flag, load o_scd_data=i_data[g], pulse o_ready[g], latch last_q=i_last[g], then go to WAIT_BUSY.
- WAIT_BUSY: stay until i_tx_busy=1, then go to WAIT_DONE. This tolerates 1..n cycles of uart_tx start latency.
- WAIT_DONE: on i_tx_busy=0:
  - If last_q=1: clear o_grant, set rr_ptr=(g+1) mod N_REQ, go to IDLE.
  - Else return to GRANT.
- Requests and bytes:
  - Non-owner requests are ignored until IDLE; no preemption.
  - i_valid/i_data from non-owners are ignored.
  - o_ready never pulses more than once per uart frame.
- Timing:
  - Minimum spacing between strobes is one full uart frame plus 2 cycles.
  - Back-to-back packets from different requesters: IDLE→GRANT costs 1 cycle after the last frame ends.
- Single requester: it may re-win immediately after its own packet when no other requester is asserting.
- Arithmetic: rr_ptr is $clog2(N_REQ) bits and wraps from N_REQ-1 to 0 explicitly (not by power-of-two overflow).

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs while in GRANT with i_valid[g]=0 and resets on each accepted byte.
  - When it reaches TIMEOUT_CYC-1: pulse o_abort[g], clear o_grant, advance rr_ptr past g, go to IDLE.
  - The counter does not run in the WAIT states.
- Without the macro: no counter; o_abort is constant 0; a stalled owner holds the TX indefinitely.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, GRANT, WAIT_BUSY, WAIT_DONE).
  - CLK_FREQ=50_000_000 and BAUD_RATE=9600, shared with uart_rx/uart_tx.
  - Byte width 8.
- One natural sub-module: rr_pick. It is purely combinational: given the request vector and rr_ptr, it returns a one-hot winner.

Test Plan (uart_tx model: busy rises 1 cycle after strobe, lasts 20 cycles; N_REQ=3):
- Single packet: req0 sends 0x5A,0x6A (last on 0x6A) → strobes carry 0x5A then 0x6A; exactly 2 o_ready[0] pulses; o_grant returns to 000 after busy falls.
- Contention: req0,req1,req2 all raised in the same cycle with 1-byte packets 0x11,0x22,0x33 → uart order 0x11,0x22,0x33.
- Fairness: req0 and req1 both raised again → rr_ptr=0 after the prior sequence, so order 0x11,0x22. Keep req0 continuously asserted → req1 is served between consecutive req0 packets.
- Busy hold-off: force i_tx_busy=1 for 50 cycles while the owner is valid → no strobe and no o_ready until busy falls; strobe occurs the cycle busy is low.
- Abandon/reset: owner drops i_req in GRANT → o_grant=000 next cycle, no strobe. Assert i_rst_n=0 during WAIT_DONE → next cycle all outputs are 0 and the FSM is in IDLE.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYC=100: owner gives no valid for 100 cycles → o_abort[g] pulses once and the next requester is granted.
